// File: rtl/issue_replay_buffer_pkg.sv
// Shared types and constants for the issue replay buffer: the ID/EX packet
// layout, the NOP packet shown on empty ways, and the rollback encoding.
package issue_replay_buffer_pkg;

  localparam int WAYS = 2;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [4:0]  ZERO_REG = 5'd0;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [4:0]  dest_reg_idx;
    logic        rd_mem;
    logic        wr_mem;
  } id_ex_packet_t;

  localparam id_ex_packet_t NOP_PACKET = '{
    valid:        1'b0,
    inst:         NOP_INST,
    dest_reg_idx: ZERO_REG,
    rd_mem:       1'b0,
    wr_mem:       1'b0
  };

  typedef enum logic [1:0] {
    RB_NONE = 2'd0,
    RB_WAY1 = 2'd1,
    RB_BOTH = 2'd2
  } rollback_t;

endpackage

// File: rtl/issue_replay_buffer_if.sv
// Decoder-side and hazard-unit-side signals of the issue replay buffer.
// The buffer takes the slave modport; whoever drives decode/rollback takes master.
interface issue_replay_buffer_if #(
  parameter int DEPTH = 4
);
  import issue_replay_buffer_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                 squash;
  id_ex_packet_t        in_packet_0;
  id_ex_packet_t        in_packet_1;
  logic                 in_ready;
  logic [1:0]           rollback;
  id_ex_packet_t        id_packet_0;
  id_ex_packet_t        id_packet_1;
  logic [CNT_W-1:0]     occupancy;

  modport master (
    output squash, in_packet_0, in_packet_1, rollback,
    input  in_ready, id_packet_0, id_packet_1, occupancy
  );

  modport slave (
    input  squash, in_packet_0, in_packet_1, rollback,
    output in_ready, id_packet_0, id_packet_1, occupancy
  );

endinterface

// File: rtl/issue_replay_buffer_issue_count.sv
// replay_issue_count: how many of the presented packets leave the buffer this
// cycle, given the held entry count and the hazard unit's rollback answer.
module replay_issue_count
  import issue_replay_buffer_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic [CNT_W-1:0] count_i,
  input  logic [1:0]       rollback_i,
  output logic [1:0]       deq_o
);

  logic [1:0] avail;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    avail = (count_i >= CNT_W'(2)) ? 2'd2 : count_i[1:0];
    deq_o = 2'd0;
    case (rollback_i)
      RB_NONE: deq_o = avail;
      RB_WAY1: deq_o = (avail != 2'd0) ? 2'd1 : 2'd0;
      default: deq_o = 2'd0;  // RB_BOTH, and the illegal encoding 3
    endcase
  end

endmodule

// File: rtl/issue_replay_buffer.sv
// 2-in/2-out in-order replay queue between decode and hazard detection.
// Optional performance counters are enabled by defining REPLAY_PERF_CNT_EN.
module issue_replay_buffer
  import issue_replay_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  issue_replay_buffer_if.slave  bus
`ifdef REPLAY_PERF_CNT_EN
  ,
  output logic [31:0]           rollback_cycles,
  output logic [31:0]           full_stall_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  id_ex_packet_t    mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       enq;
  logic [1:0]       deq;
  logic             illegal_in;
  logic             in_ready;

  replay_issue_count #(.CNT_W(CNT_W)) u_issue_count (
    .count_i    (count_q),
    .rollback_i (bus.rollback),
    .deq_o      (deq)
  );

  assign in_ready   = (count_q <= CNT_W'(DEPTH - 2));
  assign illegal_in = bus.in_packet_1.valid && !bus.in_packet_0.valid;

  always_comb begin
    enq = 2'd0;
    if (in_ready && !illegal_in)
      enq = {1'b0, bus.in_packet_0.valid} + {1'b0, bus.in_packet_1.valid};
  end

  always_comb begin
    count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    head_d  = head_q + PTR_W'(deq);
    tail_d  = tail_q + PTR_W'(enq);
    if (bus.squash) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: the payload array has no reset; count_q alone decides which slots are meaningful.
  always_ff @(posedge clock) begin
    if (!bus.squash && enq != 2'd0) begin
      mem_q[tail_q] <= bus.in_packet_0;
      if (enq == 2'd2)
        mem_q[tail_q + PTR_W'(1)] <= bus.in_packet_1;
    end
  end

  // Outputs depend only on registered state; unused ways read as NOP.
  assign bus.in_ready    = in_ready;
  assign bus.occupancy   = count_q;
  assign bus.id_packet_0 = (count_q >= CNT_W'(1)) ? mem_q[head_q] : NOP_PACKET;
  assign bus.id_packet_1 = (count_q >= CNT_W'(2)) ? mem_q[head_q + PTR_W'(1)] : NOP_PACKET;

`ifdef REPLAY_PERF_CNT_EN
  logic [31:0] rollback_cycles_q;
  logic [31:0] full_stall_cycles_q;

  // Cleared by reset only; squash leaves the statistics intact.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rollback_cycles_q   <= '0;
      full_stall_cycles_q <= '0;
    end else begin
      if (bus.rollback != 2'd0 && count_q != '0 && rollback_cycles_q != '1)
        rollback_cycles_q <= rollback_cycles_q + 32'd1;
      if (!in_ready && bus.in_packet_0.valid && full_stall_cycles_q != '1)
        full_stall_cycles_q <= full_stall_cycles_q + 32'd1;
    end
  end

  assign rollback_cycles   = rollback_cycles_q;
  assign full_stall_cycles = full_stall_cycles_q;
`endif

  a_way1_needs_way0: assert property (@(posedge clock) disable iff (!reset_n)
    !illegal_in);
  a_rollback_legal: assert property (@(posedge clock) disable iff (!reset_n)
    bus.rollback != 2'd3);

endmodule

// File: tb/tb_issue_replay_buffer.sv
// Self-checking bench for issue_replay_buffer: directed scenarios plus random
// enqueue/rollback traffic compared against a queue-based reference model.
module tb_issue_replay_buffer;
  import issue_replay_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  issue_replay_buffer_if #(.DEPTH(DEPTH)) bus ();

`ifdef REPLAY_PERF_CNT_EN
  logic [31:0] rb_cycles;
  logic [31:0] stall_cycles;
`endif

  issue_replay_buffer #(.DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
`ifdef REPLAY_PERF_CNT_EN
    ,
    .rollback_cycles   (rb_cycles),
    .full_stall_cycles (stall_cycles)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int unsigned seq = 0;
  id_ex_packet_t model_q [$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic id_ex_packet_t new_pkt();
    id_ex_packet_t p;
    seq++;
    p.valid        = 1'b1;
    p.inst         = {seq[15:0], 16'($urandom)};
    p.dest_reg_idx = 5'($urandom_range(1, 31));
    p.rd_mem       = 1'($urandom);
    p.wr_mem       = 1'($urandom);
    return p;
  endfunction

  function automatic id_ex_packet_t idle_pkt();
    id_ex_packet_t p;
    p       = new_pkt();
    p.valid = 1'b0;
    return p;
  endfunction

  task automatic check_outputs(input string tag);
    id_ex_packet_t e0, e1;
    int n;
    n  = model_q.size();
    e0 = (n >= 1) ? model_q[0] : NOP_PACKET;
    e1 = (n >= 2) ? model_q[1] : NOP_PACKET;
    check_eq({tag, ".occ"}, 64'(bus.occupancy),   64'(n));
    check_eq({tag, ".rdy"}, 64'(bus.in_ready),    64'(n <= DEPTH - 2));
    check_eq({tag, ".id0"}, 64'(bus.id_packet_0), 64'(e0));
    check_eq({tag, ".id1"}, 64'(bus.id_packet_1), 64'(e1));
  endtask

  // Drive one cycle, advance the reference model, then check after the edge.
  task automatic step(input id_ex_packet_t p0, input id_ex_packet_t p1,
                      input logic [1:0] rb, input logic sq, input string tag);
    int n, issue;
    bit ready;
    bus.in_packet_0 = p0;
    bus.in_packet_1 = p1;
    bus.rollback    = rb;
    bus.squash      = sq;
    n     = model_q.size();
    ready = (n <= DEPTH - 2);
    if (sq) begin
      model_q.delete();
    end else begin
      if (rb == 2'd0)      issue = (n < 2) ? n : 2;
      else if (rb == 2'd1) issue = (n < 1) ? n : 1;
      else                 issue = 0;
      repeat (issue) void'(model_q.pop_front());
      if (ready && p0.valid) begin
        model_q.push_back(p0);
        if (p1.valid) model_q.push_back(p1);
      end
    end
    @(posedge clock);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    id_ex_packet_t a, b, c, d, e, f, g;
    bus.in_packet_0 = idle_pkt();
    bus.in_packet_1 = idle_pkt();
    bus.rollback    = 2'd0;
    bus.squash      = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    check_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Two packets in, visible the next cycle.
    a = new_pkt(); b = new_pkt();
    step(a, b, 2'd0, 1'b0, "t1");
    check_eq("t1.A", 64'(bus.id_packet_0), 64'(a));
    check_eq("t1.B", 64'(bus.id_packet_1), 64'(b));

    // Fill to A,B,C,D while holding both, then release only way 0.
    c = new_pkt(); d = new_pkt();
    step(c, d, 2'd2, 1'b0, "t2fill");
    check_eq("t2.occ4", 64'(bus.occupancy), 64'd4);
    step(idle_pkt(), idle_pkt(), 2'd1, 1'b0, "t2");
    check_eq("t2.B", 64'(bus.id_packet_0), 64'(b));
    check_eq("t2.C", 64'(bus.id_packet_1), 64'(c));
    check_eq("t2.occ3", 64'(bus.occupancy), 64'd3);

    // Hold both for five cycles at count 3.
    for (int i = 0; i < 5; i++) begin
      step(idle_pkt(), idle_pkt(), 2'd2, 1'b0, $sformatf("t4_%0d", i));
      check_eq("t4.B", 64'(bus.id_packet_0), 64'(b));
      check_eq("t4.occ", 64'(bus.occupancy), 64'd3);
    end

    // Full buffer ignores inputs; a full issue frees space.
    step(idle_pkt(), idle_pkt(), 2'd1, 1'b0, "t3drain");
    e = new_pkt(); f = new_pkt();
    step(e, f, 2'd2, 1'b0, "t3fill");
    check_eq("t3.full_rdy", 64'(bus.in_ready), 64'd0);
    step(new_pkt(), new_pkt(), 2'd2, 1'b0, "t3ignore");
    check_eq("t3.still4", 64'(bus.occupancy), 64'd4);
    step(new_pkt(), new_pkt(), 2'd0, 1'b0, "t3issue");
    check_eq("t3.occ2", 64'(bus.occupancy), 64'd2);
    check_eq("t3.rdy1", 64'(bus.in_ready), 64'd1);
    check_eq("t3.E", 64'(bus.id_packet_0), 64'(e));

    // Squash beats concurrent enqueue and dequeue.
    step(new_pkt(), new_pkt(), 2'd0, 1'b1, "t5");
    check_eq("t5.occ0", 64'(bus.occupancy), 64'd0);
    check_eq("t5.nop0", 64'(bus.id_packet_0), 64'(NOP_PACKET));

    // Single entry with full issue empties the buffer.
    g = new_pkt();
    step(g, idle_pkt(), 2'd2, 1'b0, "t6fill");
    check_eq("t6.G", 64'(bus.id_packet_0), 64'(g));
    step(idle_pkt(), idle_pkt(), 2'd0, 1'b0, "t6");
    check_eq("t6.nop0", 64'(bus.id_packet_0), 64'(NOP_PACKET));

    // Asynchronous reset in the middle of operation.
    step(new_pkt(), new_pkt(), 2'd2, 1'b0, "prerst");
    reset_n = 1'b0;
    #1;
    model_q.delete();
    check_outputs("asyncrst");
    bus.in_packet_0 = idle_pkt();
    bus.in_packet_1 = idle_pkt();
    @(negedge clock);
    reset_n = 1'b1;
    step(idle_pkt(), idle_pkt(), 2'd0, 1'b0, "postrst");

    // Random traffic across pointer wrap.
    for (int i = 0; i < 120; i++) begin
      id_ex_packet_t p0, p1;
      logic [1:0] rb;
      logic sq;
      p0 = ($urandom_range(0, 3) != 0) ? new_pkt() : idle_pkt();
      p1 = (p0.valid && $urandom_range(0, 1) == 1) ? new_pkt() : idle_pkt();
      rb = 2'($urandom_range(0, 2));
      sq = ($urandom_range(0, 24) == 0);
      step(p0, p1, rb, sq, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
